// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch-path types: fetch FSM states, FIFO entry layout and instruction size.
// WORD / INSTR_LEN fall back to 64 / 32 when constants.vh has not already defined them.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package legv8_pkg;

    localparam int unsigned WORD_W      = `WORD;
    localparam int unsigned INSTR_W     = `INSTR_LEN;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_if.sv
// Instruction-memory request/ack bus plus the Decode-side valid/ready delivery bus.
// The master modport is the prefetch unit; the slave modport is memory/Decode.
interface instr_prefetch_if;
    import legv8_pkg::*;

    logic               imem_req;
    logic [WORD_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction;
    logic [WORD_W-1:0]  instr_pc;
    logic [WORD_W-1:0]  incremented_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instruction, instr_pc, incremented_pc,
        input  imem_ack, imem_data, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instruction, instr_pc, incremented_pc,
        output imem_ack, imem_data, instr_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with single-cycle flush and occupancy count.
// The head word is valid whenever count_o is non-zero; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage, pointers and count; flush discards every entry at once
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: single-outstanding imem fetch FSM feeding a FIFO towards Decode.
// Optional PREFETCH_PERF_EN adds perf_fetched / perf_discarded event counters.
module instr_prefetch
    import legv8_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
`ifdef PREFETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_discarded,
`endif
    instr_prefetch_if.master  bus
);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = $bits(fetch_entry_t);

    fetch_state_t      state_q;
    logic [WORD_W-1:0] fetch_pc_q;
    logic [WORD_W-1:0] imem_addr_q;
    logic              imem_req_q;

    logic [CW-1:0]     count_s;
    logic [CW-1:0]     count_next_s;
    logic              room_s;
    logic              ack_s;
    logic              push_s;
    logic              pop_s;
    logic [WORD_W-1:0] pc_inc_s;
    logic [WORD_W-1:0] redirect_al_s;
    logic [1:0]        unused_pc_bits_s;
    fetch_entry_t      wr_entry_s;
    fetch_entry_t      head_s;
    logic [ENT_W-1:0]  head_bits_s;

    assign ack_s            = imem_req_q && bus.imem_ack;
    assign pop_s            = bus.instr_valid && bus.instr_ready;
    assign push_s           = (state_q == REQ) && ack_s && !redirect;
    assign count_next_s     = count_s + CW'(push_s) - CW'(pop_s);
    assign room_s           = (count_next_s < CW'(DEPTH));
    assign pc_inc_s         = fetch_pc_q + WORD_W'(INSTR_BYTES);
    assign redirect_al_s    = {redirect_pc[WORD_W-1:2], 2'b00};
    assign unused_pc_bits_s = redirect_pc[1:0];
    assign wr_entry_s       = '{pc: fetch_pc_q, instr: bus.imem_data};

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (redirect),
        .data_i  (wr_entry_s),
        .data_o  (head_bits_s),
        .count_o (count_s)
    );

    // Fetch FSM: owns the request handshake, fetch PC and redirect recovery
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_q <= redirect_al_s;
            case (state_q)
                REQ, DROP: begin
                    if (bus.imem_ack) begin
                        state_q     <= REQ;
                        imem_addr_q <= redirect_al_s;
                    end else begin
                        // Unacked request must stay on the bus until memory answers it
                        state_q <= DROP;
                    end
                end
                default: begin
                    state_q     <= REQ;
                    imem_req_q  <= 1'b1;
                    imem_addr_q <= redirect_al_s;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (room_s) begin
                        state_q     <= REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_q;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        fetch_pc_q <= pc_inc_s;
                        if (room_s) begin
                            imem_addr_q <= pc_inc_s;
                        end else begin
                            state_q    <= IDLE;
                            imem_req_q <= 1'b0;
                        end
                    end else begin
                        state_q <= REQ;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_q     <= REQ;
                        imem_addr_q <= fetch_pc_q;
                    end else begin
                        state_q <= DROP;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign head_s             = fetch_entry_t'(head_bits_s);
    assign bus.imem_req       = imem_req_q;
    assign bus.imem_addr      = imem_addr_q;
    assign bus.instr_valid    = (count_s != {CW{1'b0}});
    assign bus.instruction    = head_s.instr;
    assign bus.instr_pc       = head_s.pc;
    assign bus.incremented_pc = head_s.pc + WORD_W'(INSTR_BYTES);

`ifdef PREFETCH_PERF_EN
    logic [31:0]   perf_fetched_q;
    logic [31:0]   perf_discarded_q;
    logic          drop_s;
    logic [CW-1:0] flushed_s;

    // An entry popped in a redirect cycle counts as fetched, not flushed
    assign drop_s    = ack_s && (redirect || (state_q == DROP));
    assign flushed_s = redirect ? (count_s - CW'(pop_s)) : {CW{1'b0}};

    // Free-running event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q   <= 32'd0;
            perf_discarded_q <= 32'd0;
        end else begin
            perf_fetched_q   <= perf_fetched_q + 32'(pop_s);
            perf_discarded_q <= perf_discarded_q + 32'(flushed_s) + 32'(drop_s);
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_discarded = perf_discarded_q;
`endif
endmodule
